// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one signed 16x16 multiplier among NREQ requesters.
// Two-stage pipeline: operand capture, product register; results tagged by requester.
module mult_arbiter #(
  parameter int NREQ = 4,
  parameter bit SAT  = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   a_flat,
  input  logic [16*NREQ-1:0]   b_flat,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [15:0]          rsp_data,
  output logic                 busy,
  output logic [15:0]          ops_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]       last_q;
  logic [IW-1:0]       gnt_idx;
  logic                gnt_any;
  logic [IW-1:0]       cand;
  logic signed [15:0]  sel_a;
  logic signed [15:0]  sel_b;

  logic                s1_valid;
  logic [IW-1:0]       s1_idx;
  logic signed [15:0]  s1_a;
  logic signed [15:0]  s1_b;

  logic                s2_valid;
  logic [IW-1:0]       s2_idx;
  logic signed [31:0]  s2_prod;
  logic signed [31:0]  prod;

  // Search starts one past the last winner, so the last winner has lowest priority.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    gnt     = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_q) + k) % NREQ);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (reset) gnt_any = 1'b0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == gnt_idx) begin
        sel_a = a_flat[16*i +: 16];
        sel_b = b_flat[16*i +: 16];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q   <= IW'(NREQ - 1);
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      ops_done <= '0;
    end else begin
      if (gnt_any) last_q <= gnt_idx;
      s1_valid <= gnt_any;
      s2_valid <= s1_valid;
      if (s1_valid) s2_prod <= prod;
      if (s2_valid) ops_done <= ops_done + 16'd1;
    end
  end

  // NOTE: operand and tag registers carry no reset; their valid flags qualify them.
  always_ff @(posedge clk) begin
    if (gnt_any) begin
      s1_a   <= sel_a;
      s1_b   <= sel_b;
      s1_idx <= gnt_idx;
    end
    if (s1_valid) s2_idx <= s1_idx;
  end

  assign prod = s1_a * s1_b;

  // s2_prod only loads with a new result, so rsp_data holds between results.
  generate
    if (SAT) begin : g_sat
      always_comb begin
        if (s2_prod > 32'sd32767)       rsp_data = 16'h7FFF;
        else if (s2_prod < -32'sd32768) rsp_data = 16'h8000;
        else                            rsp_data = s2_prod[15:0];
      end
    end else begin : g_trunc
      assign rsp_data = s2_prod[15:0];
    end
  endgenerate

  always_comb begin
    rsp_valid = '0;
    if (s2_valid) rsp_valid[s2_idx] = 1'b1;
  end

  assign busy = s1_valid | s2_valid;

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: truncating and saturating instances share stimulus;
// a round-robin reference predicts grants and results, a monitor checks deliveries.
module tb_mult_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16 * NREQ;

  typedef struct {
    int     due;
    int     idx;
    longint prod;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [W-1:0]    a_flat = '0;
  logic [W-1:0]    b_flat = '0;

  logic [NREQ-1:0] gnt0, gnt1, rv0, rv1;
  logic [15:0]     rd0, rd1, od0, od1;
  logic            busy0, busy1;

  mult_arbiter #(.NREQ(NREQ), .SAT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .gnt(gnt0), .rsp_valid(rv0), .rsp_data(rd0), .busy(busy0), .ops_done(od0)
  );

  mult_arbiter #(.NREQ(NREQ), .SAT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .gnt(gnt1), .rsp_valid(rv1), .rsp_data(rd1), .busy(busy1), .ops_done(od1)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  int   m_last = NREQ - 1;
  logic [15:0] exp_ops = '0;
  logic [15:0] last0 = '0;
  logic [15:0] last1 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] low16(input longint p);
    logic [63:0] t;
    t = p;
    return t[15:0];
  endfunction

  function automatic logic [15:0] sat16(input longint p);
    if (p > 32767)  return 16'h7FFF;
    if (p < -32768) return 16'h8000;
    return low16(p);
  endfunction

  // Reference arbitration: first requesting index after the previous winner.
  function automatic int pick(input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic drive(input bit rst, input logic [NREQ-1:0] r,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    int              g;
    logic [NREQ-1:0] eg;
    longint          p;
    @(posedge clk);
    #1;
    reset = rst; req = r; a_flat = a; b_flat = b;
    @(negedge clk);
    g  = rst ? -1 : pick(r);
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    check("gnt_trunc", 32'(gnt0), 32'(eg));
    check("gnt_sat", 32'(gnt1), 32'(eg));
    if (rst) m_last = NREQ - 1;
    else if (g >= 0) begin
      p = longint'($signed(a[16*g +: 16])) * longint'($signed(b[16*g +: 16]));
      q.push_back('{cyc + 2, g, p});
      m_last = g;
    end
  endtask

  function automatic logic [W-1:0] rnd_ops();
    return W'({$urandom, $urandom});
  endfunction

  // Monitor: results are due exactly two cycles after their grant.
  bit              m_due, m_busy;
  logic [NREQ-1:0] m_rv;
  logic [15:0]     m_d0, m_d1;
  always @(negedge clk) begin
    m_due  = (q.size() > 0) && (q[0].due == cyc);
    m_busy = 1'b0;
    foreach (q[i]) if (q[i].due == cyc || q[i].due == cyc + 1) m_busy = 1'b1;
    if (m_due) begin
      m_rv = '0;
      m_rv[q[0].idx] = 1'b1;
      m_d0 = low16(q[0].prod);
      m_d1 = sat16(q[0].prod);
    end else begin
      m_rv = '0; m_d0 = last0; m_d1 = last1;
    end
    check("rsp_valid_trunc", 32'(rv0), 32'(m_rv));
    check("rsp_valid_sat", 32'(rv1), 32'(m_rv));
    check("rsp_data_trunc", 32'(rd0), 32'(m_d0));
    check("rsp_data_sat", 32'(rd1), 32'(m_d1));
    check("busy_trunc", 32'(busy0), 32'(m_busy));
    check("busy_sat", 32'(busy1), 32'(m_busy));
    check("ops_done_trunc", 32'(od0), 32'(exp_ops));
    check("ops_done_sat", 32'(od1), 32'(exp_ops));
    if (m_due) begin
      void'(q.pop_front());
      exp_ops = exp_ops + 16'd1;
      last0 = m_d0;
      last1 = m_d1;
    end
    if (reset) begin
      q.delete();
      exp_ops = '0;
      last0 = '0;
      last1 = '0;
    end
  end

  logic [W-1:0] av, bv;

  initial begin
    repeat (3) drive(1'b1, '0, '0, '0);
    drive(1'b0, '0, '0, '0);
    check("reset_rsp_data", 32'(rd0), 32'h0);

    // Single operation: 3 * -5 on requester 0.
    av = '0; bv = '0;
    av[15:0] = 16'sd3; bv[15:0] = -16'sd5;
    drive(1'b0, 4'b0001, av, bv);
    repeat (3) drive(1'b0, '0, av, bv);
    check("single_ops_done", 32'(od0), 32'd1);
    check("single_data", 32'(rd0), 32'(16'hFFF1));

    // Fairness under continuous requests.
    for (int i = 0; i < 8; i++) drive(1'b0, 4'b1111, rnd_ops(), rnd_ops());

    // Overflow cases on requester 0, back-to-back.
    av = '0; bv = '0;
    av[15:0] = 16'sd300; bv[15:0] = 16'sd200;
    drive(1'b0, 4'b0001, av, bv);
    av[15:0] = -16'sd300;
    drive(1'b0, 4'b0001, av, bv);
    repeat (3) drive(1'b0, '0, av, bv);

    // Sparse: requester 2, then 0 (wrapping past 3), then 1.
    drive(1'b0, 4'b0100, rnd_ops(), rnd_ops());
    drive(1'b0, 4'b0011, rnd_ops(), rnd_ops());
    drive(1'b0, 4'b0011, rnd_ops(), rnd_ops());

    for (int i = 0; i < 300; i++) drive(1'b0, NREQ'($urandom), rnd_ops(), rnd_ops());
    repeat (3) drive(1'b0, '0, '0, '0);

    // Reset in the cycle after a grant discards the operation.
    drive(1'b0, 4'b0010, rnd_ops(), rnd_ops());
    drive(1'b1, 4'b0010, rnd_ops(), rnd_ops());
    drive(1'b1, '0, '0, '0);
    repeat (4) drive(1'b0, '0, '0, '0);
    check("midreset_ops_done", 32'(od0), 32'h0);
    check("midreset_busy", 32'(busy0), 32'h0);

    // ops_done wrap: 65535 results, then one more.
    for (int i = 0; i < 65535; i++) drive(1'b0, 4'b1111, rnd_ops(), rnd_ops());
    repeat (3) drive(1'b0, '0, '0, '0);
    check("wrap_preload", 32'(od1), 32'hFFFF);
    drive(1'b0, 4'b0100, rnd_ops(), rnd_ops());
    repeat (3) drive(1'b0, '0, '0, '0);
    check("wrap_zero", 32'(od1), 32'h0);

    check("drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL provide parameter NREQ, default 4, number of particle requesters sharing the multiplier.
REQ-002 SHALL provide parameter SAT, default 0: 0 = truncate product to low 16 bits, 1 = saturate to signed 16-bit.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  NREQ  per-requester multiply request level.
REQ-006 SHALL have port a_flat  input  16*NREQ  signed operand A; requester i uses bits [16i+15:16i].
REQ-007 SHALL have port b_flat  input  16*NREQ  signed operand B, packed the same way as a_flat.
REQ-008 SHALL have port gnt  output  NREQ  one-hot grant, combinational, valid in the cycle it is issued.
REQ-009 SHALL have port rsp_valid  output  NREQ  one-hot one-cycle result strobe, bit = original requester.
REQ-010 SHALL have port rsp_data  output  16  signed product, meaningful only while any rsp_valid bit is high.
REQ-011 SHALL have port busy  output  1  high while any pipeline stage holds a valid operation.
REQ-012 SHALL have port ops_done  output  16  count of results delivered, wraps modulo 2^16.

Function
REQ-013 SHALL assert at most one gnt bit per cycle, and only for a requester whose req is high in that cycle.
REQ-014 SHALL arbitrate round-robin: search starts at (last_granted+1) mod NREQ and takes the first requester with req high.
REQ-015 SHALL update last_granted only in cycles where a grant is issued.
REQ-016 SHALL capture the granted requester's operands and index into stage 1 at the clock edge ending the grant cycle T.
REQ-017 SHALL require requesters to hold operands stable from req assertion through the grant cycle; later operand changes have no effect on the captured operation.
REQ-018 SHALL treat req still high in the cycle after a grant as a new request (back-to-back ops allowed).
REQ-019 SHALL register the full 32-bit signed product of the stage-1 operands into stage 2 at the edge ending cycle T+1.
REQ-020 SHALL drive rsp_valid[i] high for exactly cycle T+2, together with rsp_data, for an operation granted to requester i in cycle T.
REQ-021 SHALL sustain one grant and one result per cycle, with no bubbles under continuous requests.
REQ-022 With SAT=0, rsp_data SHALL equal product[15:0].
REQ-023 With SAT=1, rsp_data SHALL clamp to 32767 if product > 32767, clamp to -32768 if product < -32768, else equal product[15:0].
REQ-024 SHALL drive rsp_valid all-zero and hold rsp_data at its previous value in cycles without a result.
REQ-025 SHALL assert busy whenever the stage-1 or stage-2 valid flag is set.
REQ-026 SHALL increment ops_done by 1 at the edge ending each rsp_valid cycle, wrapping 0xFFFF -> 0x0000.
REQ-027 SHALL issue no grant when req is all-zero, and SHALL keep last_granted unchanged in that case.

Reset
REQ-028 On reset, the block SHALL clear both pipeline valid flags, set last_granted = NREQ-1 (requester 0 has first priority), and set ops_done = 0, rsp_data = 0, busy = 0.
REQ-029 SHALL force gnt = 0 while reset is high; rsp_valid is then all-zero because both valid flags are clear.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight operations, and SHALL NOT deliver them after reset deasserts.

Verification
REQ-031 Single op: req=0001, a0=3, b0=-5 in cycle T -> gnt=0001 in T; rsp_valid=0001 and rsp_data=-15 in T+2; ops_done=1.
REQ-032 Fairness: req=1111 held for 8 cycles after reset -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; 8 results, each tagged to the matching requester and delivered 2 cycles after its grant.
REQ-033 Overflow: a=300, b=200 -> SAT=0 gives rsp_data=-5536; SAT=1 gives 32767. a=-300, b=200 with SAT=1 -> -32768.
REQ-034 Sparse requests: req=0100 granted, then req=0011 -> next grant goes to requester 0 (search wraps past index 3), then to requester 1.
REQ-035 Reset mid-flight: grant in cycle T, reset in cycle T+1 -> no rsp_valid in T+2 or later; busy=0 and ops_done=0 after reset.
REQ-036 Wrap: preload ops_done to 0xFFFF via 65535 ops, then one more op -> ops_done=0x0000.
